// File: rtl/hazard_scoreboard.sv
// In-order issue controller: tracks in-flight writes per architectural register,
// stalls decode on RAW / saturation hazards and squashes decode after a redirect.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          R0_ZERO      = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs1,
    input  logic                        id_rs1_used,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs2,
    input  logic                        id_rs2_used,
    input  logic [$clog2(NUM_REGS)-1:0] id_rd,
    input  logic                        id_rd_we,
    input  logic                        wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
    input  logic                        flush,
    output logic                        issue,
    output logic                        if_id_we,
    output logic                        id_ex_nop,
    output logic [NUM_REGS-1:0]         busy,
    output logic [15:0]                 stall_cnt,
    output logic                        err
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned FC_W  = 2;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [FC_W-1:0]   flush_left;
    logic [CNT_W-1:0]  cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              rd_full;
    logic              hazard;
    logic              decode_live;

    // Hazard terms read only registered counts: no same-cycle writeback bypass.
    always_comb begin
        rs1_hit = id_rs1_used && (cnt[id_rs1] != '0) && !(R0_ZERO && (id_rs1 == '0));
        rs2_hit = id_rs2_used && (cnt[id_rs2] != '0) && !(R0_ZERO && (id_rs2 == '0));
        rd_full = id_rd_we && (cnt[id_rd] == CNT_W'(MAX_INFLIGHT)) && !(R0_ZERO && (id_rd == '0));
        hazard  = rs1_hit || rs2_hit || rd_full;
    end

    // Flush outranks hazard: the decode slot is squashed and IF/ID keeps advancing.
    assign decode_live = !rst && !flush && (state != S_FLUSH) && id_valid;
    assign issue       = decode_live && !hazard;
    assign id_ex_nop   = !issue;
    assign if_id_we    = !(decode_live && hazard);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        busy    = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = issue && id_rd_we && (id_rd == IDX_W'(r)) && !(R0_ZERO && (r == 0));
            dec_vec[r] = wb_valid && (wb_rd == IDX_W'(r)) && (cnt[r] != '0);
            busy[r]    = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    cnt[r] <= cnt[r] + CNT_W'(1);
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
            if (wb_valid && (cnt[wb_rd] == '0)) begin
                err <= 1'b1;
            end
            if (!if_id_we && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // Issue FSM; the flush counter holds remaining squash cycles after the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            flush_left <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (flush) begin
                        state      <= S_FLUSH;
                        flush_left <= FC_W'(FLUSH_CYCLES - 1);
                    end else if (id_valid && hazard) begin
                        state <= S_STALL;
                    end
                end
                S_STALL: begin
                    if (flush) begin
                        state      <= S_FLUSH;
                        flush_left <= FC_W'(FLUSH_CYCLES - 1);
                    end else if (!(id_valid && hazard)) begin
                        state <= S_RUN;
                    end
                end
                S_FLUSH: begin
                    if (flush) begin
                        flush_left <= FC_W'(FLUSH_CYCLES - 1);
                    end else if (flush_left == '0) begin
                        state <= S_RUN;
                    end else begin
                        flush_left <= flush_left - FC_W'(1);
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       rst_z;
    logic       id_valid;
    logic [2:0] id_rs1;
    logic       id_rs1_used;
    logic [2:0] id_rs2;
    logic       id_rs2_used;
    logic [2:0] id_rd;
    logic       id_rd_we;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic       flush;

    logic        issue_a, if_id_we_a, id_ex_nop_a, err_a;
    logic [7:0]  busy_a;
    logic [15:0] stall_cnt_a;
    logic        issue_b, if_id_we_b, id_ex_nop_b, err_b;
    logic [7:0]  busy_b;
    logic [15:0] stall_cnt_b;

    hazard_scoreboard #(.NUM_REGS(8), .MAX_INFLIGHT(3), .FLUSH_CYCLES(2), .R0_ZERO(1'b0)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .issue(issue_a), .if_id_we(if_id_we_a), .id_ex_nop(id_ex_nop_a),
        .busy(busy_a), .stall_cnt(stall_cnt_a), .err(err_a)
    );

    hazard_scoreboard #(.NUM_REGS(8), .MAX_INFLIGHT(3), .FLUSH_CYCLES(2), .R0_ZERO(1'b1)) dut_z (
        .clk(clk), .rst(rst_z), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .issue(issue_b), .if_id_we(if_id_we_b), .id_ex_nop(id_ex_nop_b),
        .busy(busy_b), .stall_cnt(stall_cnt_b), .err(err_b)
    );

    typedef struct {
        string       name;
        bit          sel;
        logic [27:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    logic [27:0] got;
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected packing: {issue, if_id_we, id_ex_nop, busy, stall_cnt, err}
    task automatic step(input string name, input int r, input int rz, input int v,
                        input int rs1, input int u1, input int rs2, input int u2,
                        input int rd, input int we, input int wbv, input int wbrd, input int fl,
                        input int e_iss, input int e_we, input int e_busy, input int e_st,
                        input int e_err, input int sel);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = 1'(r);
        rst_z       = 1'(rz);
        id_valid    = 1'(v);
        id_rs1      = 3'(rs1);
        id_rs1_used = 1'(u1);
        id_rs2      = 3'(rs2);
        id_rs2_used = 1'(u2);
        id_rd       = 3'(rd);
        id_rd_we    = 1'(we);
        wb_valid    = 1'(wbv);
        wb_rd       = 3'(wbrd);
        flush       = 1'(fl);
        e.name = name;
        e.sel  = 1'(sel);
        e.exp  = {1'(e_iss), 1'(e_we), ~1'(e_iss), 8'(e_busy), 16'(e_st), 1'(e_err)};
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            got = cur.sel ? {issue_b, if_id_we_b, id_ex_nop_b, busy_b, stall_cnt_b, err_b}
                          : {issue_a, if_id_we_a, id_ex_nop_a, busy_a, stall_cnt_a, err_a};
            checks++;
            if (got !== cur.exp) begin
                errors++;
                $display("FAIL %s: got iss/we/nop/busy/stall/err=%b/%b/%b/%h/%h/%b expected %b/%b/%b/%h/%h/%b",
                         cur.name, got[27], got[26], got[25], got[24:17], got[16:1], got[0],
                         cur.exp[27], cur.exp[26], cur.exp[25], cur.exp[24:17], cur.exp[16:1], cur.exp[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rst_z = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs1_used = 1'b0;
        id_rs2 = '0; id_rs2_used = 1'b0; id_rd = '0; id_rd_we = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        //   name              r rz v rs1 u1 rs2 u2 rd we wbv wbrd fl | iss we busy  st err sel
        step("reset",          1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 'h00, 0, 0, 0);
        step("issue_r3",       0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   1, 1, 'h00, 0, 0, 0);
        step("raw_stall0",     0, 1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0,   0, 0, 'h08, 0, 0, 0);
        step("raw_stall1",     0, 1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0,   0, 0, 'h08, 1, 0, 0);
        step("raw_wb_no_byp",  0, 1, 1, 3, 1, 0, 0, 4, 1, 1, 3, 0,   0, 0, 'h08, 2, 0, 0);
        step("raw_issue",      0, 1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0,   1, 1, 'h00, 3, 0, 0);
        step("busy_r4",        0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 'h10, 3, 0, 0);
        step("wb_r4",          0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0,   0, 1, 'h10, 3, 0, 0);
        step("sat_w1",         0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   1, 1, 'h00, 3, 0, 0);
        step("sat_w2",         0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   1, 1, 'h20, 3, 0, 0);
        step("sat_w3",         0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   1, 1, 'h20, 3, 0, 0);
        step("sat_stall",      0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 0, 'h20, 3, 0, 0);
        step("sat_wb",         0, 1, 1, 0, 0, 0, 0, 5, 1, 1, 5, 0,   0, 0, 'h20, 4, 0, 0);
        step("sat_issue",      0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   1, 1, 'h20, 5, 0, 0);
        step("flush_haz",      0, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 1,   0, 1, 'h20, 5, 0, 0);
        step("flush_sq1",      0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 'h20, 5, 0, 0);
        step("flush_sq2",      0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 'h20, 5, 0, 0);
        step("flush_run",      0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   1, 1, 'h20, 5, 0, 0);
        step("busy_r1",        0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 'h22, 5, 0, 0);
        step("issue_r2",       0, 1, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0,   1, 1, 'h22, 5, 0, 0);
        step("inc_dec_r2",     0, 1, 1, 0, 0, 0, 0, 2, 1, 1, 2, 0,   1, 1, 'h26, 5, 0, 0);
        step("r2_still_busy",  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 'h26, 5, 0, 0);
        step("wb_r2",          0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0,   0, 1, 'h26, 5, 0, 0);
        step("r2_idle",        0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 'h22, 5, 0, 0);
        step("spurious_wb",    0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0,   0, 1, 'h22, 5, 0, 0);
        step("err_set",        0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 'h22, 5, 1, 0);
        step("err_sticky",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 'h22, 5, 1, 0);
        step("rs2_stall",      0, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 0, 'h22, 5, 1, 0);
        step("rst_mid_stall",  1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 1, 'h22, 6, 1, 0);
        step("after_rst",      0, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0,   1, 1, 'h00, 0, 0, 0);
        step("r0_write",       0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 1, 'h00, 0, 0, 1);
        step("r0_read",        0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0,   1, 1, 'h00, 0, 0, 1);
        step("r0_not_busy",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 'h00, 0, 0, 1);
        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
In-order issue controller between the decode stage and the ID/EX pipeline register of the 16-bit core. It tracks the writes still in flight to each of the 8 architectural registers. It stalls decode on RAW hazards or when a destination's in-flight count is saturated, by holding IF/ID and injecting a bubble into ID/EX. A small FSM squashes decode for a fixed number of cycles after a branch redirect.

Parameters:
NUM_REGS, 8, architectural registers; index width is 3 bits.
MAX_INFLIGHT, 3, maximum writes in flight per register (EX, MEM, WB); the per-register counter is 2 bits wide.
FLUSH_CYCLES, 2, bubble cycles injected after a flush; legal range 1..3.
R0_ZERO, 0, when 1, register 0 is never marked pending and never causes a stall.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a valid instruction
id_rs1  in  3  source register 1
id_rs1_used  in  1  rs1 is read by the instruction
id_rs2  in  3  source register 2
id_rs2_used  in  1  rs2 is read by the instruction
id_rd  in  3  destination register
id_rd_we  in  1  instruction writes rd
wb_valid  in  1  writeback retires a register write this cycle
wb_rd  in  3  register written back
flush  in  1  branch redirect from EX, single-cycle pulse
issue  out  1  decode instruction passes into ID/EX this cycle
if_id_we  out  1  IF/ID write enable; 0 holds IF/ID
id_ex_nop  out  1  ID/EX receives a bubble
busy  out  8  bit r is 1 when cnt[r] != 0
stall_cnt  out  16  saturating count of stall cycles
err  out  1  sticky: writeback seen for a register with cnt 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=RUN; all cnt=0; busy=0; stall_cnt=0; err=0; flush counter=0.
  - While rst is high: issue=0, id_ex_nop=1, if_id_we=1.
  - Reset mid-stall or mid-flush drops all state; in-flight writes are forgotten.
- hazard, combinational on current registered counts:
  - true if (id_rs1_used and cnt[id_rs1]!=0), or (id_rs2_used and cnt[id_rs2]!=0), or (id_rd_we and cnt[id_rd]==MAX_INFLIGHT).
  - There is no same-cycle writeback bypass: a hazard clears on the cycle after the retiring wb_valid.
  - When R0_ZERO=1, any term involving register 0 is false.
- States:
  - RUN: flush -> FLUSH, loading the flush counter with FLUSH_CYCLES-1. Else id_valid and hazard -> STALL. Else stay.
  - STALL: flush -> FLUSH. Else id_valid and hazard -> stay. Else -> RUN.
  - FLUSH: if flush again, reload the counter. Else if counter==0 -> RUN. Else decrement.
- Outputs, combinational:
  - issue = !rst and !flush and state!=FLUSH and id_valid and !hazard.
  - id_ex_nop = !issue.
  - if_id_we = 0 only when (!rst and !flush and state!=FLUSH and id_valid and hazard); otherwise 1.
  - flush has priority over hazard in the same cycle: the decode instruction is squashed, not issued, and IF/ID is written.
- Counters, per register r, each cycle:
  - inc = issue and id_rd_we and id_rd==r (inc is never 1 when R0_ZERO=1 and r==0).
  - dec = wb_valid and wb_rd==r and cnt[r]!=0.
  - cnt[r] <= cnt[r] + inc - dec. Simultaneous inc and dec leaves cnt unchanged.
  - inc never fires at MAX_INFLIGHT, because the hazard blocks issue.
  - wb_valid with cnt[wb_rd]==0: cnt stays 0 and err <= 1 until reset.
- Flush behaviour:
  - Flush does not clear counts; instructions already in EX/MEM/WB still retire.
- Performance counter:
  - stall_cnt increments on every cycle with if_id_we==0.
  - It saturates at 16'hFFFF and does not wrap.
- Latency:
  - Zero-cycle issue decision when hazard-free.
  - busy reflects the update one cycle after issue or wb.

Test Plan:
- Reset, then id_valid=1, rd=3, rd_we=1, no sources -> issue=1, id_ex_nop=0 in the same cycle; next cycle busy=8'b0000_1000.
- RAW: issue write r3, then decode reads rs1=3 -> if_id_we=0, id_ex_nop=1, state STALL. wb_valid with wb_rd=3 at cycle t -> issue=1 at t+1; stall_cnt equals the stall-cycle count.
- Saturation: 3 issues writing r5 with no wb -> the 4th writer of r5 stalls. One wb of r5 -> it issues next cycle; busy[5] stays 1.
- Flush plus hazard in the same cycle with FLUSH_CYCLES=2 -> issue=0 and if_id_we=1 for the flush cycle plus 2 more cycles. Then RUN, with counts unchanged.
- Same-cycle issue writing r2 and wb of r2 with cnt[2]=1 -> cnt[2] stays 1. Spurious wb of r6 with cnt 0 -> err=1, held until rst. rst mid-STALL -> next cycle busy=0, state RUN.
- R0_ZERO=1: issue write r0, then read r0 -> no stall, busy[0]=0.
